// File: rtl/memShare_config_pkg.sv
// Shared constants and state type for the L1PA register-file loader.
// Imported by the loader top level and its page assembler.
package memShare_config_pkg;

    localparam int L1PA_REGFILE_PAGE_NUM   = 8;
    localparam int L1PA_REGFILE_PAGE_WIDTH = 10;
    localparam int L1PA_REGFILE_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } l1pa_ldr_state_e;

    function automatic int wordsPerPage(input int pageW, input int wordW);
        return (pageW + wordW - 1) / wordW;
    endfunction

endpackage

// File: rtl/l1pa_regfile_loader_if.sv
// Valid/ready word stream carrying configuration data into the loader.
// The master drives data and valid; the slave returns ready.
interface l1pa_regfile_loader_if #(
    parameter int W = 4
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, input ready);
endinterface

// File: rtl/l1pa_page_assembler.sv
// Packs LSB-first stream words into one register-file page.
// Bits of the last word beyond the page width are dropped.
module l1pa_page_assembler
    import memShare_config_pkg::*;
#(
    parameter int CFG_WORD_WIDTH = 4,
    parameter int PAGE_WIDTH     = L1PA_REGFILE_PAGE_WIDTH
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  clr,
    l1pa_regfile_loader_if.slave  cfg,
    output logic [PAGE_WIDTH-1:0] pageNxt,
    output logic                  pageLast
);

    localparam int WPP   = wordsPerPage(PAGE_WIDTH, CFG_WORD_WIDTH);
    localparam int CNT_W = (WPP > 1) ? $clog2(WPP) : 1;

    logic [PAGE_WIDTH-1:0] asmQ;
    logic [CNT_W-1:0]      wordCnt;
    logic                  accept;

    assign accept   = cfg.valid & cfg.ready;
    assign pageLast = accept && (wordCnt == CNT_W'(WPP - 1));

    // Page as it will look once the word on the bus is taken.
    always_comb begin
        pageNxt = asmQ;
        for (int b = 0; b < PAGE_WIDTH; b++) begin
            if (wordCnt == CNT_W'(b / CFG_WORD_WIDTH)) begin
                pageNxt[b] = cfg.data[b % CFG_WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            asmQ    <= '0;
            wordCnt <= '0;
        end else if (clr) begin
            asmQ    <= '0;
            wordCnt <= '0;
        end else if (accept) begin
            asmQ    <= pageNxt;
            wordCnt <= pageLast ? '0 : wordCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/l1pa_regfile_loader.sv
// Loads a run of register-file pages from a word stream and writes
// each page to the regType0 port one cycle after its last word.
module l1pa_regfile_loader
    import memShare_config_pkg::*;
#(
    parameter int CFG_WORD_WIDTH = 4,
    parameter int PAGE_NUM       = L1PA_REGFILE_PAGE_NUM,
    parameter int PAGE_WIDTH     = L1PA_REGFILE_PAGE_WIDTH,
    parameter int ADDR_WIDTH     = L1PA_REGFILE_ADDR_WIDTH
) (
    input  logic                      sys_clk,
    input  logic                      rstn,
    input  logic                      start_i,
    input  logic [ADDR_WIDTH:0]       page_cnt_i,
    input  logic [CFG_WORD_WIDTH-1:0] cfg_data_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    output logic [ADDR_WIDTH-1:0]     regType0_waddr_o,
    output logic [PAGE_WIDTH-1:0]     regType0_wdata_o,
    output logic                      regType0_we_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    l1pa_ldr_state_e       state;
    logic [ADDR_WIDTH-1:0] pageIdx;
    logic [ADDR_WIDTH:0]   pageCnt;
    logic                  startOk;
    logic                  lastPage;
    logic                  clr;
    logic                  pageLast;
    logic [PAGE_WIDTH-1:0] pageNxt;

    l1pa_regfile_loader_if #(.W(CFG_WORD_WIDTH)) cfgIf ();

    assign cfgIf.data  = cfg_data_i;
    assign cfgIf.valid = cfg_valid_i;
    assign cfgIf.ready = cfg_ready_o;

    assign startOk  = start_i
                   && (page_cnt_i != '0)
                   && (page_cnt_i <= (ADDR_WIDTH + 1)'(PAGE_NUM));
    assign clr      = (state == IDLE) && startOk;
    assign lastPage = ({1'b0, pageIdx} == (pageCnt - 1'b1));

    l1pa_page_assembler #(
        .CFG_WORD_WIDTH (CFG_WORD_WIDTH),
        .PAGE_WIDTH     (PAGE_WIDTH)
    ) u_asm (
        .sys_clk  (sys_clk),
        .rstn     (rstn),
        .clr      (clr),
        .cfg      (cfgIf.slave),
        .pageNxt  (pageNxt),
        .pageLast (pageLast)
    );

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            pageIdx          <= '0;
            pageCnt          <= '0;
            cfg_ready_o      <= 1'b0;
            regType0_waddr_o <= '0;
            regType0_wdata_o <= '0;
            regType0_we_o    <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (startOk) begin
                        state       <= COLLECT;
                        pageIdx     <= '0;
                        pageCnt     <= page_cnt_i;
                        err_o       <= 1'b0;
                        busy_o      <= 1'b1;
                        cfg_ready_o <= 1'b1;
                    end else if (start_i) begin
                        err_o <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (pageLast) begin
                        state            <= WRITE;
                        cfg_ready_o      <= 1'b0;
                        regType0_we_o    <= 1'b1;
                        regType0_waddr_o <= pageIdx;
                        regType0_wdata_o <= pageNxt;
                    end
                end
                WRITE: begin
                    regType0_we_o <= 1'b0;
                    if (lastPage) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        state       <= COLLECT;
                        pageIdx     <= pageIdx + 1'b1;
                        cfg_ready_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1pa_regfile_loader.sv
// Randomised directed bench for the L1PA register-file loader.
// Expected pages come from packing three 4-bit words into 10 bits.
module tb_l1pa_regfile_loader;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       startI = 1'b0;
    logic [3:0] pageCntI = '0;
    logic [2:0] waddr;
    logic [9:0] wdata;
    logic       we;
    logic       busy;
    logic       done;
    logic       err;

    int chk = 0;
    int errs = 0;
    int cyc = 0;
    int rdyInWr = 0;

    logic [3:0]  words [24];
    logic [12:0] wrQ [$];
    int          wrCyc [$];

    l1pa_regfile_loader_if #(.W(4)) cfg ();

    l1pa_regfile_loader #(
        .CFG_WORD_WIDTH (4),
        .PAGE_NUM       (8),
        .PAGE_WIDTH     (10),
        .ADDR_WIDTH     (3)
    ) dut (
        .sys_clk          (clk),
        .rstn             (rstn),
        .start_i          (startI),
        .page_cnt_i       (pageCntI),
        .cfg_data_i       (cfg.data),
        .cfg_valid_i      (cfg.valid),
        .cfg_ready_o      (cfg.ready),
        .regType0_waddr_o (waddr),
        .regType0_wdata_o (wdata),
        .regType0_we_o    (we),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            wrQ.push_back({waddr, wdata});
            wrCyc.push_back(cyc);
            if (cfg.ready) rdyInWr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expData(input int p);
        int v;
        v = int'(words[3*p]) | (int'(words[3*p+1]) << 4)
          | (int'(words[3*p+2]) << 8);
        return 32'(v & 'h3FF);
    endfunction

    task automatic fillWords();
        for (int i = 0; i < 24; i++) words[i] = 4'($urandom_range(15));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input logic [3:0] cnt);
        startI = 1'b1;
        pageCntI = cnt;
        step();
        startI = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ready"}, 32'(cfg.ready), 0);
        check({tag, "_we"}, 32'(we), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_waddr"}, 32'(waddr), 0);
        check({tag, "_wdata"}, 32'(wdata), 0);
    endtask

    task automatic runLoad(input int n, input int pct, input bit poke,
                           input int stopAt);
        int acc;
        int guard;
        int lastAcc;
        int total;
        bit poked;
        total = (stopAt >= 0) ? stopAt : 3 * n;
        wrQ.delete();
        wrCyc.delete();
        pulseStart(4'(n));
        check("start_busy", 32'(busy), 1);
        check("start_err", 32'(err), 0);
        acc = 0;
        guard = 0;
        lastAcc = 0;
        poked = 1'b0;
        while (acc < total && guard < 1000) begin
            startI = 1'b0;
            cfg.valid = ($urandom_range(99) < pct);
            cfg.data = words[acc];
            if (poke && !poked && acc == 4) begin
                startI = 1'b1;
                pageCntI = 4'd1;
                poked = 1'b1;
            end
            if (cfg.valid && cfg.ready) begin
                lastAcc = cyc;
                acc++;
            end
            step();
            guard++;
        end
        cfg.valid = 1'b0;
        startI = 1'b0;
        check("feed_count", 32'(acc), 32'(total));
        if (stopAt >= 0) return;
        guard = 0;
        while (!done && guard < 20) begin
            step();
            guard++;
        end
        check("done_seen", 32'(done), 1);
        check("done_latency", 32'(cyc - lastAcc), 2);
        check("write_count", 32'(wrQ.size()), 32'(n));
        for (int p = 0; p < n && p < wrQ.size(); p++) begin
            check("waddr", 32'(wrQ[p][12:10]), 32'(p));
            check("wdata", 32'(wrQ[p][9:0]), expData(p));
        end
        if (wrCyc.size() == n) check("we_latency", 32'(wrCyc[n-1] - lastAcc), 1);
        step();
        check("done_pulse", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("we_low", 32'(we), 0);
        check("hold_waddr", 32'(waddr), 32'(n - 1));
        check("hold_wdata", 32'(wdata), expData(n - 1));
    endtask

    initial begin
        int hits;
        cfg.valid = 1'b0;
        cfg.data = '0;
        #1 rstn = 1'b0;
        #2 checkAllZero("reset");
        @(negedge clk) rstn = 1'b1;
        step();

        // page 0 from 0xA, 0x5, 0xF
        words[0] = 4'hA;
        words[1] = 4'h5;
        words[2] = 4'hF;
        runLoad(1, 100, 1'b0, -1);
        check("page0_35A", (wrQ.size() > 0) ? 32'(wrQ[0][9:0]) : 32'hFFFF, 'h35A);

        fillWords();
        runLoad(8, 100, 1'b0, -1);

        fillWords();
        runLoad(2, 50, 1'b0, -1);

        wrQ.delete();
        pulseStart(4'd0);
        check("cnt0_err", 32'(err), 1);
        check("cnt0_busy", 32'(busy), 0);
        check("cnt0_ready", 32'(cfg.ready), 0);
        pulseStart(4'd9);
        check("cnt9_err", 32'(err), 1);
        check("cnt9_busy", 32'(busy), 0);
        repeat (3) step();
        check("err_nowrite", 32'(wrQ.size()), 0);
        fillWords();
        runLoad(1, 100, 1'b0, -1);

        fillWords();
        runLoad(8, 100, 1'b0, 11);
        rstn = 1'b0;
        #1 checkAllZero("midreset");
        repeat (2) step();
        @(negedge clk) rstn = 1'b1;
        repeat (2) step();
        hits = 0;
        foreach (wrQ[i]) if (wrQ[i][12:10] == 3'd3) hits++;
        check("no_addr3", 32'(hits), 0);
        check("partial_writes", 32'(wrQ.size()), 3);
        check("post_reset_busy", 32'(busy), 0);
        fillWords();
        runLoad(3, 70, 1'b0, -1);

        fillWords();
        runLoad(3, 100, 1'b1, -1);

        check("ready_in_write", 32'(rdyInWr), 0);

        $display("Result: errors=%0d of %0d checks", errs, chk);
        $finish;
    end

endmodule

// File: doc/l1pa_regfile_loader.md
L1PA_REGFILE_LOADER -- requirements
Module: l1pa_regfile_loader

Interface
REQ-001 The block SHALL have parameter CFG_WORD_WIDTH, default 4: width of one configuration stream word.
REQ-002 The block SHALL have parameter PAGE_NUM, default L1PA_REGFILE_PAGE_NUM: number of register-file pages.
REQ-003 The block SHALL have parameter PAGE_WIDTH, default L1PA_REGFILE_PAGE_WIDTH: bits per page.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default L1PA_REGFILE_ADDR_WIDTH: page address width.
REQ-005 The block SHALL have port sys_clk, input, 1: single clock, rising edge.
REQ-006 The block SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port start_i, input, 1: one-cycle load request.
REQ-008 The block SHALL have port page_cnt_i, input, ADDR_WIDTH+1: pages to load, sampled at start_i.
REQ-009 The block SHALL have port cfg_data_i, input, CFG_WORD_WIDTH: stream word, LSB-first within a page.
REQ-010 The block SHALL have port cfg_valid_i, input, 1: stream word valid.
REQ-011 The block SHALL have port cfg_ready_o, output, 1: stream word accepted when valid and ready are both 1.
REQ-012 The block SHALL have port regType0_waddr_o, output, ADDR_WIDTH: register-file write address.
REQ-013 The block SHALL have port regType0_wdata_o, output, PAGE_WIDTH: register-file write data.
REQ-014 The block SHALL have port regType0_we_o, output, 1: register-file write enable.
REQ-015 The block SHALL have port busy_o, output, 1: load in progress.
REQ-016 The block SHALL have port done_o, output, 1: one-cycle pulse on load completion.
REQ-017 The block SHALL have port err_o, output, 1: sticky error flag, cleared by the next accepted start_i.

Function
REQ-018 WORDS_PER_PAGE SHALL equal ceil(PAGE_WIDTH/CFG_WORD_WIDTH); within a page, word k SHALL fill bits [k*CFG_WORD_WIDTH +: CFG_WORD_WIDTH], and bits beyond PAGE_WIDTH in the last word SHALL be discarded.
REQ-019 The state machine SHALL have states IDLE, COLLECT, WRITE and DONE.
REQ-020 IDLE -> COLLECT SHALL occur on start_i when 1 <= page_cnt_i <= PAGE_NUM; on that transition the page index resets to 0, the word counter resets to 0 and err_o clears.
REQ-021 If start_i arrives in IDLE with page_cnt_i equal to 0 or greater than PAGE_NUM, err_o SHALL be set to 1 and the state SHALL remain IDLE.
REQ-022 start_i SHALL be ignored in every state other than IDLE.
REQ-023 cfg_ready_o SHALL be 1 only in COLLECT; words SHALL be accepted only on valid-and-ready cycles, and cfg_valid_i idle cycles SHALL be tolerated with no timeout.
REQ-024 Acceptance of word WORDS_PER_PAGE-1 SHALL cause COLLECT -> WRITE.
REQ-025 In WRITE, for exactly one cycle, regType0_we_o SHALL be 1, regType0_waddr_o SHALL equal the page index and regType0_wdata_o SHALL equal the assembled page.
REQ-026 Write latency SHALL be 1: we_o is asserted in the cycle after the last word of a page is accepted.
REQ-027 From WRITE, the machine SHALL go to DONE if page index = page_cnt-1; otherwise it SHALL increment the page index and return to COLLECT.
REQ-028 DONE SHALL last one cycle with done_o = 1 and then return to IDLE.
REQ-029 done_o SHALL occur 2 cycles after the final word is accepted.
REQ-030 busy_o SHALL be 1 in COLLECT, WRITE and DONE.
REQ-031 Outside WRITE, regType0_we_o SHALL be 0; regType0_waddr_o and regType0_wdata_o SHALL hold their last values.
REQ-032 The page index SHALL never wrap; the maximum index written is PAGE_NUM-1.

Reset
REQ-033 While rstn = 0, the state SHALL be IDLE and cfg_ready_o, regType0_we_o, busy_o, done_o and err_o SHALL be 0.
REQ-034 While rstn = 0, regType0_waddr_o, regType0_wdata_o, the page index, the word counter and the assembly register SHALL be 0.
REQ-035 A reset asserted mid-load SHALL abort the load without any partial-page write; after release, the block SHALL wait in IDLE for a new start_i.

Structure
REQ-036 The L1PA_REGFILE_* constants and a state enum typedef l1pa_ldr_state_e SHALL live in memShare_config_pkg.
REQ-037 The word-to-page assembler (shift/insert register plus word counter) SHALL be one sub-module named l1pa_page_assembler; the FSM SHALL stay in the top level.
REQ-038 The outputs SHALL connect directly to the regType0_* write port of memShare_control_wrapper.

Verification
REQ-039 Bench config SHALL be PAGE_NUM=8, PAGE_WIDTH=10, CFG_WORD_WIDTH=4, giving 3 words per page.
REQ-040 Scenario: start with page_cnt=8 and continuous valid words -> 8 writes, addresses 0..7, data matching the bit-packed stream, done_o 2 cycles after the 24th accepted word.
REQ-041 Scenario: page 0 words 0xA, 0x5, 0xF -> wdata = 10'h35A, with the upper 2 bits of 0xF dropped.
REQ-042 Scenario: valid toggled randomly with page_cnt=2 -> the 6 accepted words produce the same writes as the gap-free case, and ready is 0 during WRITE.
REQ-043 Scenario: page_cnt=0, then page_cnt=9 -> err_o=1, no writes, busy_o=0; a following valid start clears err_o.
REQ-044 Scenario: rstn pulsed low after the 2nd word of page 3 -> no write to address 3, all outputs 0, and a fresh load then succeeds.
REQ-045 Scenario: start_i pulsed during COLLECT -> ignored, and the page sequence is unchanged.
